// File: rtl/amo_engine.sv
// amo_engine: single-outstanding atomic memory operation engine.
//
// Takes one AMO request at a time, does a read-modify-write on the memory
// port and returns the original memory value.
//
// Optional feature macro: AMO_ENGINE_LRSC_EN adds LR/SC support with a
// single reservation granule. Without it, LR and SC are illegal requests.
//
// Ports:
//   clk, reset                          clock, async active-high reset
//   ReqValid/ReqReady                   request handshake
//   ReqFunct7, ReqFunct3, ReqAdr,       operation, width, address, operand
//   ReqWData
//   RspValid, RspData, RspIllegal       one-cycle response pulse and result
//   MemReq, MemWrite, MemAdr, MemWData  memory request (held until MemAck)
//   MemAck, MemRData                    memory completion and read data
//   SnoopValid, SnoopAdr                external write notification
//   DbgState                            current FSM state
//
// Handshake: a request transfers on a rising edge where ReqValid and ReqReady
// are both 1; ReqReady is 1 only in IDLE. A memory request is held with
// stable address/data until the edge on which MemAck is 1. RspValid is a
// single-cycle pulse with no backpressure.
module amo_engine #(
    parameter int XLEN      = 64,
    parameter int PA_BITS   = 56,
    parameter int RESV_LOG2 = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [6:0]         ReqFunct7,
    input  logic [2:0]         ReqFunct3,
    input  logic [PA_BITS-1:0] ReqAdr,
    input  logic [XLEN-1:0]    ReqWData,
    output logic               RspValid,
    output logic [XLEN-1:0]    RspData,
    output logic               RspIllegal,
    output logic               MemReq,
    output logic               MemWrite,
    output logic [PA_BITS-1:0] MemAdr,
    output logic [XLEN-1:0]    MemWData,
    input  logic               MemAck,
    input  logic [XLEN-1:0]    MemRData,
    input  logic               SnoopValid,
    input  logic [PA_BITS-1:0] SnoopAdr,
    output logic [2:0]         DbgState
);
    typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, RESP} state_t;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    state_t            r_state;
    logic [4:0]        r_f5;
    logic              r_word;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_mem;

    logic [4:0]        w_f5;
    logic              w_word_in;
    logic              w_legal;
    logic              w_op_ok;
    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    logic [XLEN-1:0]   w_y;
    logic [XLEN-1:0]   w_y_ext;

    // Sign-extend from bit 31; identity when XLEN is 32.
    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        logic signed [31:0] lo;
        lo = x[31:0];
        return XLEN'(lo);
    endfunction

    assign DbgState  = r_state;
    assign w_f5      = ReqFunct7[6:2];
    assign w_word_in = (ReqFunct3[1:0] == 2'b10);

    // Request legality: known operation, supported width, size-aligned address.
    always_comb begin
        w_op_ok = 1'b0;
        case (w_f5)
            F_ADD, F_SWAP, F_XOR, F_OR, F_AND,
            F_MIN, F_MAX, F_MINU, F_MAXU: w_op_ok = 1'b1;
`ifdef AMO_ENGINE_LRSC_EN
            F_LR, F_SC:                   w_op_ok = 1'b1;
`endif
            default:                      w_op_ok = 1'b0;
        endcase
        w_legal = w_op_ok;
        if (ReqFunct3[1:0] == 2'b10)
            w_legal = w_legal && (ReqAdr[1:0] == 2'b00);
        else if (XLEN == 64 && ReqFunct3[1:0] == 2'b11)
            w_legal = w_legal && (ReqAdr[2:0] == 3'b000);
        else
            w_legal = 1'b0;
    end

    // ALU: operands are sign-extended for word ops; ties in min/max keep a.
    always_comb begin
        w_a = r_word ? sext_w(r_mem)   : r_mem;
        w_b = r_word ? sext_w(r_wdata) : r_wdata;
        case (r_f5)
            F_SWAP:  w_y = w_b;
            F_ADD:   w_y = w_a + w_b;
            F_XOR:   w_y = w_a ^ w_b;
            F_AND:   w_y = w_a & w_b;
            F_OR:    w_y = w_a | w_b;
            F_MIN:   w_y = ($signed(w_b) < $signed(w_a)) ? w_b : w_a;
            F_MAX:   w_y = ($signed(w_a) < $signed(w_b)) ? w_b : w_a;
            F_MINU:  w_y = (w_b < w_a) ? w_b : w_a;
            F_MAXU:  w_y = (w_a < w_b) ? w_b : w_a;
            default: w_y = w_b;
        endcase
        w_y_ext = r_word ? sext_w(w_y) : w_y;
    end

`ifdef AMO_ENGINE_LRSC_EN
    logic                          r_res_valid;
    logic [PA_BITS-RESV_LOG2-1:0]  r_res_adr;
    logic                          w_snoop_hit;
    logic                          w_sc_ok;
    logic                          w_unused;
    assign w_snoop_hit = SnoopValid && (SnoopAdr[PA_BITS-1:RESV_LOG2] == r_res_adr);
    // A snoop to the reserved granule in the decision cycle makes the SC fail.
    assign w_sc_ok     = r_res_valid && !w_snoop_hit &&
                         (ReqAdr[PA_BITS-1:RESV_LOG2] == r_res_adr);
    assign w_unused    = ^{ReqFunct7[1:0], ReqFunct3[2]};
`else
    logic w_unused;
    assign w_unused = ^{ReqFunct7[1:0], ReqFunct3[2], SnoopValid, SnoopAdr};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_f5       <= '0;
            r_word     <= 1'b0;
            r_wdata    <= '0;
            r_mem      <= '0;
            ReqReady   <= 1'b1;
            RspValid   <= 1'b0;
            RspIllegal <= 1'b0;
            RspData    <= '0;
            MemReq     <= 1'b0;
            MemWrite   <= 1'b0;
            MemAdr     <= '0;
            MemWData   <= '0;
`ifdef AMO_ENGINE_LRSC_EN
            r_res_valid <= 1'b0;
            r_res_adr   <= '0;
`endif
        end else begin
            RspValid   <= 1'b0;
            RspIllegal <= 1'b0;
`ifdef AMO_ENGINE_LRSC_EN
            if (w_snoop_hit)
                r_res_valid <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (ReqValid) begin
                        ReqReady <= 1'b0;
                        r_f5     <= w_f5;
                        r_word   <= w_word_in;
                        r_wdata  <= ReqWData;
                        if (!w_legal) begin
                            r_state    <= RESP;
                            RspValid   <= 1'b1;
                            RspIllegal <= 1'b1;
                            RspData    <= '0;
                        end
`ifdef AMO_ENGINE_LRSC_EN
                        else if (w_f5 == F_SC) begin
                            r_res_valid <= 1'b0;
                            if (w_sc_ok) begin
                                r_state  <= WRITE;
                                MemReq   <= 1'b1;
                                MemWrite <= 1'b1;
                                MemAdr   <= ReqAdr;
                                MemWData <= w_word_in ? sext_w(ReqWData) : ReqWData;
                                RspData  <= '0;
                            end else begin
                                r_state  <= RESP;
                                RspValid <= 1'b1;
                                RspData  <= XLEN'(1);
                            end
                        end
`endif
                        else begin
                            r_state  <= READ;
                            MemReq   <= 1'b1;
                            MemWrite <= 1'b0;
                            MemAdr   <= ReqAdr;
                        end
                    end
                end
                READ: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        r_mem  <= MemRData;
`ifdef AMO_ENGINE_LRSC_EN
                        if (r_f5 == F_LR) begin
                            r_state  <= RESP;
                            RspValid <= 1'b1;
                            RspData  <= r_word ? sext_w(MemRData) : MemRData;
                            // A snoop to the same granule on the ack cycle
                            // prevents the reservation from being taken.
                            if (!(SnoopValid && SnoopAdr[PA_BITS-1:RESV_LOG2] ==
                                                MemAdr[PA_BITS-1:RESV_LOG2])) begin
                                r_res_valid <= 1'b1;
                                r_res_adr   <= MemAdr[PA_BITS-1:RESV_LOG2];
                            end
                        end else
`endif
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_state  <= WRITE;
                    MemReq   <= 1'b1;
                    MemWrite <= 1'b1;
                    MemWData <= w_y_ext;
                    RspData  <= w_a;
                end
                WRITE: begin
                    if (MemAck) begin
                        MemReq   <= 1'b0;
                        MemWrite <= 1'b0;
                        r_state  <= RESP;
                        RspValid <= 1'b1;
                    end
                end
                RESP: begin
                    r_state  <= IDLE;
                    ReqReady <= 1'b1;
                end
                default: begin
                    r_state  <= IDLE;
                    ReqReady <= 1'b1;
                    MemReq   <= 1'b0;
                    MemWrite <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_amo_engine.sv
module tb_amo_engine;
  localparam int XLEN = 64;
  localparam int PA_BITS = 56;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MAXU = 5'b11100;
  localparam logic [2:0] W = 3'b010;
  localparam logic [2:0] D = 3'b011;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               ReqValid = 1'b0;
  logic               ReqReady;
  logic [6:0]         ReqFunct7 = '0;
  logic [2:0]         ReqFunct3 = '0;
  logic [PA_BITS-1:0] ReqAdr = '0;
  logic [XLEN-1:0]    ReqWData = '0;
  logic               RspValid;
  logic [XLEN-1:0]    RspData;
  logic               RspIllegal;
  logic               MemReq;
  logic               MemWrite;
  logic [PA_BITS-1:0] MemAdr;
  logic [XLEN-1:0]    MemWData;
  logic               MemAck = 1'b0;
  logic [XLEN-1:0]    MemRData = '0;
  logic               SnoopValid = 1'b0;
  logic [PA_BITS-1:0] SnoopAdr = '0;
  logic [2:0]         DbgState;

  amo_engine #(.XLEN(XLEN), .PA_BITS(PA_BITS), .RESV_LOG2(3)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqFunct7(ReqFunct7), .ReqFunct3(ReqFunct3),
    .ReqAdr(ReqAdr), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspData(RspData), .RspIllegal(RspIllegal),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAdr(MemAdr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData),
    .SnoopValid(SnoopValid), .SnoopAdr(SnoopAdr),
    .DbgState(DbgState)
  );

  // scoreboard state
  int n_vec = 0;
  int n_fail = 0;
  logic [XLEN-1:0] exp_q[$];

  // memory model state
  logic [XLEN-1:0]    mem [128];
  int                 mem_wait = 0;
  logic               hold_write = 1'b0;
  int                 n_writes = 0;
  int                 memreq_cycles = 0;
  logic [PA_BITS-1:0] last_wadr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Responds on the falling edge so MemAck is stable at the next rising edge.
  task automatic mem_model();
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (MemReq) memreq_cycles++;
      if (MemReq && !MemAck && !(MemWrite && hold_write)) begin
        if (wait_cnt == mem_wait) begin
          MemAck = 1'b1;
          wait_cnt = 0;
          if (MemWrite) begin
            mem[MemAdr[9:3]] = MemWData;
            n_writes++;
            last_wadr = MemAdr;
          end else begin
            MemRData = mem[MemAdr[9:3]];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        MemAck = 1'b0;
        if (!MemReq) wait_cnt = 0;
      end
    end
  endtask

  // Drives one request; lat counts cycles from acceptance to RspValid (0 = timeout).
  task automatic do_req(input logic [4:0] f5, input logic [2:0] f3,
                        input logic [PA_BITS-1:0] adr, input logic [XLEN-1:0] wd,
                        output int lat, output logic [XLEN-1:0] rdata, output logic ill);
    @(negedge clk);
    ReqValid  = 1'b1;
    ReqFunct7 = {f5, 2'b00};
    ReqFunct3 = f3;
    ReqAdr    = adr;
    ReqWData  = wd;
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
    lat = 0;
    rdata = '0;
    ill = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (RspValid) begin
        lat = i;
        rdata = RspData;
        ill = RspIllegal;
        break;
      end
    end
  endtask

  function automatic int idx(input logic [PA_BITS-1:0] a);
    return int'(a[9:3]);
  endfunction

  initial begin
    int lat;
    logic [XLEN-1:0] rd;
    logic ill;
    int w0;
    logic found;

    for (int i = 0; i < 128; i++) mem[i] = '0;
    fork
      mem_model();
    join_none

    // reset state, while asserted and after release
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, ReqReady}, 64'd1);
    check("rst_rspvalid", {63'd0, RspValid}, 64'd0);
    check("rst_memreq", {63'd0, MemReq}, 64'd0);
    check("rst_memadr", {8'd0, MemAdr}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready", {63'd0, ReqReady}, 64'd1);
    check("rel_rspill", {63'd0, RspIllegal}, 64'd0);
    check("rel_rspdata", RspData, 64'd0);
    check("rel_memwrite", {63'd0, MemWrite}, 64'd0);
    check("rel_memwdata", MemWData, 64'd0);

    // amoadd.d overflow to the sign bit
    mem[idx(56'h100)] = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_q.push_back(64'h8000_0000_0000_0000);
    do_req(F_ADD, D, 56'h100, 64'd1, lat, rd, ill);
    check("add_lat", 64'(lat), 64'd4);
    check("add_rsp", rd, 64'h7FFF_FFFF_FFFF_FFFF);
    check("add_ill", {63'd0, ill}, 64'd0);
    check("add_mem", mem[idx(56'h100)], exp_q.pop_front());
    check("add_wadr", {8'd0, last_wadr}, 64'h100);

    // amomin.w: signed compare on low word, sign-extended result
    mem[idx(56'h108)] = 64'h0000_0000_8000_0000;
    exp_q.push_back(64'hFFFF_FFFF_8000_0000);
    do_req(F_MIN, W, 56'h108, 64'h0000_0000_0000_0001, lat, rd, ill);
    check("minw_lat", 64'(lat), 64'd4);
    check("minw_rsp", rd, 64'hFFFF_FFFF_8000_0000);
    check("minw_mem", mem[idx(56'h108)], exp_q.pop_front());

    // amomax.w: upper bits of memory ignored, positive word wins
    mem[idx(56'h110)] = 64'h1234_5678_7FFF_FFFF;
    exp_q.push_back(64'h0000_0000_7FFF_FFFF);
    do_req(F_MAX, W, 56'h110, 64'h0000_0000_8000_0000, lat, rd, ill);
    check("maxw_rsp", rd, 64'h0000_0000_7FFF_FFFF);
    check("maxw_mem", mem[idx(56'h110)], exp_q.pop_front());

    // amomaxu.d with two wait cycles on each memory access
    mem_wait = 2;
    mem[idx(56'h118)] = 64'd5;
    do_req(F_MAXU, D, 56'h118, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd, ill);
    check("maxu_lat", 64'(lat), 64'd8);
    check("maxu_rsp", rd, 64'd5);
    check("maxu_mem", mem[idx(56'h118)], 64'hFFFF_FFFF_FFFF_FFFF);
    mem_wait = 0;

    // amoxor.d
    mem[idx(56'h120)] = 64'h0000_F0F0;
    do_req(F_XOR, D, 56'h120, 64'h0000_FF00, lat, rd, ill);
    check("xor_rsp", rd, 64'h0000_F0F0);
    check("xor_mem", mem[idx(56'h120)], 64'h0000_0FF0);

    // illegal: misaligned word swap
    memreq_cycles = 0;
    do_req(F_SWAP, W, 56'h1002, 64'h55, lat, rd, ill);
    check("mis_lat", 64'(lat), 64'd1);
    check("mis_ill", {63'd0, ill}, 64'd1);
    check("mis_rsp", rd, 64'd0);
    check("mis_memreq", 64'(memreq_cycles), 64'd0);

    // illegal: bad width, bad funct5, misaligned double
    do_req(F_ADD, 3'b001, 56'h100, 64'd1, lat, rd, ill);
    check("bad_f3_ill", {63'd0, ill}, 64'd1);
    do_req(5'b00101, D, 56'h100, 64'd1, lat, rd, ill);
    check("bad_f5_ill", {63'd0, ill}, 64'd1);
    do_req(F_ADD, D, 56'h104, 64'd1, lat, rd, ill);
    check("mis_d_ill", {63'd0, ill}, 64'd1);
    check("illegal_memreq", 64'(memreq_cycles), 64'd0);

`ifdef AMO_ENGINE_LRSC_EN
    mem[idx(56'h100)] = 64'h1234;
    do_req(F_LR, D, 56'h100, 64'd0, lat, rd, ill);
    check("lr_lat", 64'(lat), 64'd2);
    check("lr_rsp", rd, 64'h1234);
    do_req(F_SC, D, 56'h100, 64'd5, lat, rd, ill);
    check("sc_lat", 64'(lat), 64'd2);
    check("sc_rsp", rd, 64'd0);
    check("sc_mem", mem[idx(56'h100)], 64'd5);
    w0 = n_writes;
    do_req(F_SC, D, 56'h100, 64'd9, lat, rd, ill);
    check("sc2_lat", 64'(lat), 64'd1);
    check("sc2_rsp", rd, 64'd1);
    check("sc2_nowrite", 64'(n_writes - w0), 64'd0);
    do_req(F_LR, D, 56'h100, 64'd0, lat, rd, ill);
    @(negedge clk);
    SnoopValid = 1'b1;
    SnoopAdr = 56'h104;
    @(negedge clk);
    SnoopValid = 1'b0;
    do_req(F_SC, D, 56'h100, 64'd7, lat, rd, ill);
    check("snoop_sc_rsp", rd, 64'd1);
    check("snoop_sc_mem", mem[idx(56'h100)], 64'd5);
`else
    do_req(F_LR, D, 56'h100, 64'd0, lat, rd, ill);
    check("lr_ill", {63'd0, ill}, 64'd1);
    do_req(F_SC, D, 56'h100, 64'd5, lat, rd, ill);
    check("sc_ill", {63'd0, ill}, 64'd1);
`endif

    // reset during WRITE with the write ack withheld
    hold_write = 1'b1;
    mem[idx(56'h140)] = 64'h0F;
    @(negedge clk);
    ReqValid  = 1'b1;
    ReqFunct7 = {F_OR, 2'b00};
    ReqFunct3 = D;
    ReqAdr    = 56'h140;
    ReqWData  = 64'hF0;
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (MemWrite) begin
        found = 1'b1;
        break;
      end
    end
    check("rw_reached_write", {63'd0, found}, 64'd1);
    reset = 1'b1;
    #1;
    check("rw_memreq", {63'd0, MemReq}, 64'd0);
    check("rw_memwrite", {63'd0, MemWrite}, 64'd0);
    check("rw_ready", {63'd0, ReqReady}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    hold_write = 1'b0;
    @(negedge clk);
    check("rw_ready_rel", {63'd0, ReqReady}, 64'd1);
    check("rw_mem_untouched", mem[idx(56'h140)], 64'h0F);
    do_req(F_OR, D, 56'h140, 64'hF0, lat, rd, ill);
    check("or_lat", 64'(lat), 64'd4);
    check("or_rsp", rd, 64'h0F);
    check("or_mem", mem[idx(56'h140)], 64'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute time limit so a stuck run still reports.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end
endmodule
